// File: rtl/alu_pkg.sv
// Shared types for the ALU request sequencer: ALU command encoding, sequencer states
// and the ALU word width.
package alu_pkg;

    localparam int WORD_W = 6;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        RROT = 2'b01,
        NAND = 2'b10,
        NOP  = 2'b11
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } seq_state_t;

    // Only ADD and NAND have a meaningful two-word form; others run as a single pass.
    function automatic logic is_two_word(alu_cmd_t cmd, logic wide);
        return wide && ((cmd == ADD) || (cmd == NAND));
    endfunction

endpackage

// File: rtl/alu_req_arbiter.sv
// Request arbiter: valid vector + last-grant pointer -> one-hot grant and its index.
// ALU_SEQ_RR_EN selects round-robin; otherwise fixed priority with the lowest index winning.
module alu_req_arbiter #(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

`ifdef ALU_SEQ_RR_EN
    function automatic logic [ID_W-1:0] wrap_id(int v);
        return ID_W'(v % NREQ);
    endfunction

    // Walk from farthest to nearest after the pointer so the nearest valid requester wins.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred on idle paths.
        grant    = '0;
        grant_id = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (valid[wrap_id(int'(ptr) + i)]) begin
                grant    = '0;
                grant[wrap_id(int'(ptr) + i)] = 1'b1;
                grant_id = wrap_id(int'(ptr) + i);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred on idle paths.
        grant    = '0;
        grant_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one WORD_W-bit ALU between NREQ requesters, chaining carry for two-word ADD/NAND.
// Define ALU_SEQ_RR_EN for round-robin arbitration; default is fixed priority.
module alu_req_sequencer #(
    parameter  int NREQ   = 2,
    parameter  int WORD_W = alu_pkg::WORD_W,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_cmd,
    input  logic [NREQ-1:0]          req_wide,
    input  logic [2*WORD_W*NREQ-1:0] req_a,
    input  logic [2*WORD_W*NREQ-1:0] req_b,
    output logic [1:0]               alu_cmd,
    output logic [WORD_W-1:0]        alu_inA,
    output logic [WORD_W-1:0]        alu_inB,
    output logic                     alu_sc_i,
    input  logic [WORD_W-1:0]        alu_rslt,
    input  logic                     alu_sc_o,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WORD_W-1:0]      rsp_rslt,
    output logic                     rsp_sc,
    output logic                     rsp_zero
);
    import alu_pkg::*;

    seq_state_t          state_q, state_d;
    alu_cmd_t            cmd_q;
    logic                wide_q;
    logic [2*WORD_W-1:0] a_q, b_q;
    logic [ID_W-1:0]     id_q;
    logic [WORD_W-1:0]   lo_q;
    logic                carry_q;

    logic [NREQ-1:0]     grant;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     arb_ptr;
    alu_cmd_t            grant_cmd;

    assign grant_cmd = alu_cmd_t'(req_cmd[int'(grant_id)*2 +: 2]);

`ifdef ALU_SEQ_RR_EN
    logic [ID_W-1:0] ptr_q;
    assign arb_ptr = ptr_q;

    // Pointer holds the last granted id; reset value makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= ID_W'(NREQ - 1);
        end else if (state_q == IDLE && |req_valid) begin
            ptr_q <= grant_id;
        end
    end
`else
    assign arb_ptr = '0;
`endif

    alu_req_arbiter #(.NREQ(NREQ)) u_arbiter (
        .valid    (req_valid),
        .ptr      (arb_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        alu_cmd   = NOP;
        alu_inA   = '0;
        alu_inB   = '0;
        alu_sc_i  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    state_d   = LO;
                end
            end
            LO: begin
                alu_cmd = cmd_q;
                alu_inA = a_q[WORD_W-1:0];
                alu_inB = b_q[WORD_W-1:0];
                state_d = wide_q ? HI : RESP;
            end
            HI: begin
                alu_cmd  = cmd_q;
                alu_inA  = a_q[2*WORD_W-1:WORD_W];
                alu_inB  = b_q[2*WORD_W-1:WORD_W];
                alu_sc_i = (cmd_q == ADD) ? carry_q : 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A grant during reset would be lost, so none is advertised.
        if (reset) begin
            req_ready = '0;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= NOP;
            wide_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            lo_q     <= '0;
            carry_q  <= 1'b0;
            rsp_rslt <= '0;
            rsp_sc   <= 1'b0;
            rsp_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        cmd_q  <= grant_cmd;
                        wide_q <= is_two_word(grant_cmd, req_wide[grant_id]);
                        a_q    <= req_a[int'(grant_id)*2*WORD_W +: 2*WORD_W];
                        b_q    <= req_b[int'(grant_id)*2*WORD_W +: 2*WORD_W];
                        id_q   <= grant_id;
                    end
                end
                LO: begin
                    lo_q    <= alu_rslt;
                    carry_q <= alu_sc_o;
                    if (!wide_q) begin
                        rsp_rslt <= {{WORD_W{1'b0}}, alu_rslt};
                        rsp_sc   <= alu_sc_o;
                        rsp_zero <= (alu_rslt == '0);
                    end
                end
                HI: begin
                    rsp_rslt <= {alu_rslt, lo_q};
                    rsp_sc   <= alu_sc_o;
                    rsp_zero <= (alu_rslt == '0) && (lo_q == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer with a behavioural ALU and a response model.
// Honours ALU_SEQ_RR_EN the same way as the design build.
module tb_alu_req_sequencer;

    localparam int NREQ = 2;
    localparam int W    = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid, req_ready, req_wide;
    logic [3:0]     req_cmd;
    logic [23:0]    req_a, req_b;
    logic [1:0]     alu_cmd;
    logic [W-1:0]   alu_inA, alu_inB, alu_rslt;
    logic           alu_sc_i, alu_sc_o;
    logic           rsp_valid, rsp_ready;
    logic [0:0]     rsp_id;
    logic [11:0]    rsp_rslt;
    logic           rsp_sc, rsp_zero;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int rr_ptr  = NREQ - 1;
    logic reset_prev = 1'b0;

    typedef struct {
        int          id;
        logic [11:0] rslt;
        logic        sc;
        logic        zero;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    alu_req_sequencer #(.NREQ(NREQ), .WORD_W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_wide(req_wide),
        .req_a(req_a), .req_b(req_b),
        .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rslt(rsp_rslt), .rsp_sc(rsp_sc), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: ADD with carry, rotate-right-by-one of A, NAND, NOP.
    logic [6:0] alu_sum;
    always_comb begin
        alu_sum  = {1'b0, alu_inA} + {1'b0, alu_inB} + {6'b0, alu_sc_i};
        alu_rslt = '0;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            2'b00: begin alu_rslt = alu_sum[5:0]; alu_sc_o = alu_sum[6]; end
            2'b01: alu_rslt = {alu_inA[0], alu_inA[5:1]};
            2'b10: alu_rslt = ~(alu_inA & alu_inB);
            default: alu_rslt = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Result of an operation computed on whole 12-bit operands.
    function automatic exp_t model(int id, logic [1:0] cmd, logic wide,
                                   logic [11:0] a, logic [11:0] b, int now);
        exp_t e;
        logic two;
        logic [12:0] s;
        two    = wide && (cmd == 2'b00 || cmd == 2'b10);
        e.id   = id;
        e.sc   = 1'b0;
        e.rslt = '0;
        case (cmd)
            2'b00: begin
                if (two) begin
                    s = {1'b0, a} + {1'b0, b};
                    e.rslt = s[11:0];
                    e.sc   = s[12];
                end else begin
                    s = {7'b0, a[5:0]} + {7'b0, b[5:0]};
                    e.rslt = {6'b0, s[5:0]};
                    e.sc   = s[6];
                end
            end
            2'b10:   e.rslt = two ? ~(a & b) : {6'b0, ~(a[5:0] & b[5:0])};
            2'b01:   e.rslt = {6'b0, a[0], a[5:1]};
            default: e.rslt = '0;
        endcase
        e.zero = (e.rslt == 12'd0);
        e.due  = now + (two ? 3 : 2);
        return e;
    endfunction

    function automatic int exp_grant(logic [1:0] v, int ptr);
`ifdef ALU_SEQ_RR_EN
        for (int i = 1; i <= NREQ; i++) if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
`else
        for (int i = 0; i < NREQ; i++) if (v[i]) return i + 0 * ptr;
`endif
        return -1;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int g;
        if (reset) begin
            exp_q.delete();
            rr_ptr = NREQ - 1;
            check("reset_req_ready", 32'(req_ready), 0);
            if (reset_prev) begin
                check("reset_rsp_valid", 32'(rsp_valid), 0);
                check("reset_rsp_id", 32'(rsp_id), 0);
                check("reset_rsp_rslt", 32'(rsp_rslt), 0);
                check("reset_rsp_sc", 32'(rsp_sc), 0);
                check("reset_rsp_zero", 32'(rsp_zero), 0);
                check("reset_alu_cmd", 32'(alu_cmd), 3);
                check("reset_alu_in", {alu_inA, alu_inB, alu_sc_i}, 0);
            end
        end else begin
            if (exp_q.size() == 0) begin
                g = exp_grant(req_valid, rr_ptr);
                check("grant", 32'(req_ready), (g < 0) ? 0 : (1 << g));
                if (g >= 0) begin
                    exp_q.push_back(model(g, req_cmd[2*g +: 2], req_wide[g],
                                          req_a[12*g +: 12], req_b[12*g +: 12], cyc));
                    rr_ptr = g;
                end
            end else begin
                check("no_grant_while_busy", 32'(req_ready), 0);
            end
            if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                check("rsp_valid", 32'(rsp_valid), 1);
                check("rsp_id", 32'(rsp_id), exp_q[0].id);
                check("rsp_rslt", 32'(rsp_rslt), 32'(exp_q[0].rslt));
                check("rsp_sc", 32'(rsp_sc), 32'(exp_q[0].sc));
                check("rsp_zero", 32'(rsp_zero), 32'(exp_q[0].zero));
                check("resp_alu_idle", {alu_cmd, alu_inA, alu_inB, alu_sc_i}, 32'h3 << 13);
                if (!rsp_valid || rsp_ready) void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 0);
            end
        end
        reset_prev = reset;
    end

    task automatic issue(input int id, input logic [1:0] cmd, input logic wide,
                         input logic [11:0] a, input logic [11:0] b, output int acc);
        @(posedge clk); #1;
        req_cmd[2*id +: 2]  = cmd;
        req_wide[id]        = wide;
        req_a[12*id +: 12]  = a;
        req_b[12*id +: 12]  = b;
        req_valid[id]       = 1'b1;
        acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin acc = cyc; break; end
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int id, input logic [11:0] rslt, input logic sc,
                            input logic zero, input int acc, input int lat);
        int seen = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = cyc; break; end
        end
        if (seen < 0) begin
            check("rsp_timeout", 0, 1);
        end else begin
            check("lit_latency", seen - acc, lat);
            check("lit_id", 32'(rsp_id), id);
            check("lit_rslt", 32'(rsp_rslt), 32'(rslt));
            check("lit_sc", 32'(rsp_sc), 32'(sc));
            check("lit_zero", 32'(rsp_zero), 32'(zero));
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        int ids [4];
        int want[4];
        logic [11:0] held;
        int stuck;

        reset = 1'b1; req_valid = '0; req_wide = '0; req_cmd = 4'hF;
        req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Narrow ADD with carry out, then wide ADD carrying across words.
        issue(0, 2'b00, 1'b0, 12'b000000_101010, 12'b000000_110011, acc);
        wait_rsp(0, 12'b000000_011101, 1'b1, 1'b0, acc, 2);
        issue(1, 2'b00, 1'b1, 12'b000001_111111, 12'b000000_000001, acc);
        wait_rsp(1, 12'b000010_000000, 1'b0, 1'b0, acc, 3);

        // Zero flag, NAND, wide NAND, wide RROT (one pass), full-width wrap.
        issue(0, 2'b00, 1'b0, 12'b000000_100000, 12'b000000_100000, acc);
        wait_rsp(0, 12'b0, 1'b1, 1'b1, acc, 2);
        issue(1, 2'b10, 1'b0, 12'b000000_101010, 12'b000000_110011, acc);
        wait_rsp(1, 12'b000000_011101, 1'b0, 1'b0, acc, 2);
        issue(0, 2'b10, 1'b1, 12'b111111_000000, 12'b101010_111111, acc);
        wait_rsp(0, 12'b010101_111111, 1'b0, 1'b0, acc, 3);
        issue(1, 2'b01, 1'b1, 12'b101010_000011, 12'b0, acc);
        wait_rsp(1, 12'b000000_100001, 1'b0, 1'b0, acc, 2);
        issue(0, 2'b00, 1'b1, 12'hFFF, 12'h001, acc);
        wait_rsp(0, 12'h000, 1'b1, 1'b1, acc, 3);

        // Both requesters held: arbitration order.
        do_reset(2);
        @(posedge clk); #1;
        req_cmd = 4'b0000; req_wide = 2'b00;
        req_a = {12'd2, 12'd1}; req_b = {12'd3, 12'd1};
        req_valid = 2'b11;
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin ids[n] = int'(rsp_id); n++; end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
`ifdef ALU_SEQ_RR_EN
        want = '{0, 1, 0, 1};
`else
        want = '{0, 0, 0, 0};
`endif
        check("arb_count", n, 4);
        for (int i = 0; i < 4; i++) check("arb_order", ids[i], want[i]);
        repeat (3) @(posedge clk);

        // Backpressure: response held three cycles while requester 1 waits.
        #1 rsp_ready = 1'b0;
        issue(0, 2'b00, 1'b0, 12'b000000_000111, 12'b000000_000001, acc);
        stuck = 0;
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        held = rsp_rslt;
        check("stall_first_rslt", 32'(held), 8);
        @(posedge clk); #1;
        req_cmd[3:2] = 2'b10; req_wide[1] = 1'b0;
        req_a[23:12] = 12'b000000_111100; req_b[23:12] = 12'b000000_001111;
        req_valid[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_rslt", 32'(rsp_rslt), 32'(held));
            check("stall_req_ready", 32'(req_ready), 0);
            check("stall_alu_cmd", 32'(alu_cmd), 3);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("handshake_no_grant", 32'(req_ready), 0);
        @(negedge clk);
        check("grant_after_handshake", 32'(req_ready), 2);
        acc = cyc;
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_rsp(1, 12'b000000_110011, 1'b0, 1'b0, acc, 2);

        // Reset during the high pass of a wide op discards it.
        issue(0, 2'b00, 1'b1, 12'hFFF, 12'h001, acc);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_rsp_valid", 32'(rsp_valid), 0);
        check("post_reset_rslt", 32'(rsp_rslt), 0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("no_rsp_for_discarded", n, 0);

        issue(1, 2'b10, 1'b0, 12'h03F, 12'h03F, acc);
        wait_rsp(1, 12'h000, 1'b0, 1'b1, acc, 2);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
